trace_port_capture: RTL and testbench
=====================================

Name: trace_port_capture

Overview:
- Single-clock capture front end for a 4-bit ARM TPIU parallel trace port.
- Oversamples the DDR trace clock and data in the clkIn domain and assembles bytes.
- Finds the TPIU full-sync pattern and collects aligned 16-byte (128-bit) frames into a FIFO.
- Serves frames to a host over an SPI slave interface, with status LEDs and debug strobes.

Parameters:
FIFO_DEPTH, 4, number of 128-bit frame entries in the FIFO (power of 2, ≥2)
LED_STRETCH, 2400000, clkIn cycles each LED indication is held after its triggering event
SYNC_TIMEOUT, 48000, clkIn cycles without any traceClk edge before sync is dropped

Ports:
clkIn  input  1  system clock (48 MHz); the only clock in the block
rstIn  input  1  asynchronous, active-low reset
traceDin  input  4  TPIU trace data, DDR, sampled on both traceClk edges
traceClk  input  1  TPIU trace clock, asynchronous, ≤ clkIn/8
spics  input  1  SPI chip select, active low
spiclk  input  1  SPI clock, mode 0, ≤ clkIn/8
spirx  input  1  SPI MOSI; reserved and ignored
spitx  output  1  SPI MISO
sync_led  output  1  high while frame sync is held
rxInd_led  output  1  stretched indication that a frame was stored
txInd_led  output  1  stretched indication that a frame was sent to the host
txOvf_led  output  1  stretched indication that a frame was dropped on FIFO full
cts  output  1  high while the FIFO is non-empty
D6, D5, D4, D3  output  1 each  debug: D6=sync state, D5=trace-edge strobe, D4=frame-write strobe, D3=synchronized spics

Behaviour:
Reset
- rstIn low asynchronously clears all state: unsynced, FIFO empty, counters at 0, SPI idle.
- All outputs are 0 during reset, except spitx=0 and D3=1 (idle spics).

Trace sampling
- traceClk and traceDin pass together through a 2-flop synchronizer.
- A change in synchronized traceClk, on either edge, is one trace edge; it captures the synchronized traceDin nibble in that cycle.
- Input timing: data must be stable ≥1 clkIn period before and after each traceClk edge.
- D5 pulses for 1 cycle per trace edge.

Byte assembly and sync
- Nibbles shift into a 32-bit window from the top, LSB-first: window = {nibble, window[31:4]}.
- Sync pattern is bytes FF FF FF 7F in arrival order, i.e. window == 32'h7FFFFFFF.
- On a sync match:
  - sync = 1;
  - the nibble counter resets to 0, so the next nibble is the low nibble of byte 0;
  - any partial frame is discarded.
- While synced:
  - nibble pairs form bytes (first nibble = bits[3:0]);
  - 32 nibbles form a 128-bit frame, byte 0 in bits [7:0];
  - the completed frame is written to the FIFO in the cycle after its 32nd nibble; D4 pulses for that cycle.
- A sync match always takes priority over frame completion in the same cycle.
- Sync is dropped (sync=0, partial frame discarded) after SYNC_TIMEOUT cycles with no trace edge.
- Unsynced: nibbles still feed the window; no frames are produced.

FIFO
- FIFO_DEPTH × 128 bits.
- A write when full drops the new frame, keeps stored data intact, and triggers txOvf_led.
- cts = FIFO non-empty.

SPI slave (mode 0, all signals synchronized into clkIn)
- spics falling edge: latch the FIFO head into a 128-bit shift register. If the FIFO is empty, latch all zeros and mark "no pop".
- Bit order: byte 0 first, MSB of each byte first.
- spitx is driven with the current bit while spics is low. It advances to the next bit on each synchronized spiclk falling edge. A bit counter increments on each rising edge.
- spics rising edge:
  - if exactly 128 rising edges occurred and the FIFO was non-empty at latch, pop the head and trigger txInd_led;
  - otherwise nothing is popped (aborted transfer, frame retained).
- spitx = 0 while spics is high.

LEDs
- Each LED goes high on its trigger and holds for LED_STRETCH cycles.
- A retrigger restarts the count.
- sync_led = D6 = sync, level, unstretched.
- Simultaneous FIFO write and pop in one cycle are both honoured; count unchanged.

Test Plan:
- Reset, then 8 random bytes (AA 55 AA 55 66 99 66 99) with no sync -> sync_led=0, cts=0, no FIFO write.
- Sync FF×7,7F then 16 bytes 01 23 45 67 89 AB CD EF ×2 -> sync_led=1, one frame stored, cts=1, rxInd_led=1; SPI read of 128 bits returns 01 23 … EF 01 … EF; then cts=0 and txInd_led=1.
- Sync, 2 bytes (01 23), sync again, 16-byte frame -> exactly one frame stored, containing only the second 16 bytes.
- FIFO_DEPTH+1 synced frames with no SPI reads -> cts=1, txOvf_led=1; reads return the first FIFO_DEPTH frames in order.
- SPI read aborted after 64 clocks -> frame retained; a full next read returns the same frame. A read with the FIFO empty -> 128 zero bits, no state change.
- Assert rstIn low mid-frame -> all outputs reset, sync_led=0; after release, the sync+frame sequence works as in the second scenario.

Source files
------------

// File: rtl/trace_port_capture.sv
// TPIU 4-bit trace capture: sync hunt, 128-bit frame FIFO, SPI readout.
// Ports: clkIn/rstIn, traceDin/traceClk in, spi slave, LEDs, debug D6..D3.
module trace_port_capture #(
  parameter int FIFO_DEPTH   = 4,
  parameter int LED_STRETCH  = 2400000,
  parameter int SYNC_TIMEOUT = 48000
) (
  input  logic       clkIn,
  input  logic       rstIn,
  input  logic [3:0] traceDin,
  input  logic       traceClk,
  input  logic       spics,
  input  logic       spiclk,
  input  logic       spirx,
  output logic       spitx,
  output logic       sync_led,
  output logic       rxInd_led,
  output logic       txInd_led,
  output logic       txOvf_led,
  output logic       cts,
  output logic       D6,
  output logic       D5,
  output logic       D4,
  output logic       D3
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(SYNC_TIMEOUT + 1);
  localparam int LW = $clog2(LED_STRETCH + 1);

  logic         tclk_s1_q, tclk_s2_q, tclk_prev_q;
  logic [3:0]   din_s1_q, din_s2_q;
  logic         cs_s1_q, cs_s2_q, cs_prev_q;
  logic         sck_s1_q, sck_s2_q, sck_prev_q;
  logic [31:0]  window_q, window_d;
  logic         sync_q, sync_d;
  logic [4:0]   nib_cnt_q, nib_cnt_d;
  logic [127:0] frame_q, frame_d;
  logic         wr_pend_q, wr_pend_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [127:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]  cnt_q, cnt_d;
  logic [127:0] shreg_q, shreg_d, tx_word;
  logic [7:0]   bit_cnt_q, bit_cnt_d;
  logic         no_pop_q, no_pop_d;
  logic [LW-1:0] led_cnt_q [3];
  logic [LW-1:0] led_cnt_d [3];

  logic        trace_edge, sync_hit, full, empty, wr_en, ovf, pop;
  logic        cs_fall, cs_rise, sck_rise, sck_fall;
  logic [31:0] win_shift;
  logic [2:0]  trig;
  logic        unused_spirx;

  assign unused_spirx = spirx;

  assign trace_edge = tclk_s2_q ^ tclk_prev_q;
  assign win_shift  = {din_s2_q, window_q[31:4]};
  assign sync_hit   = trace_edge && (win_shift == 32'h7FFF_FFFF);

  always_comb begin
    window_d  = window_q;
    sync_d    = sync_q;
    nib_cnt_d = nib_cnt_q;
    frame_d   = frame_q;
    wr_pend_d = 1'b0;
    to_cnt_d  = to_cnt_q;
    if (trace_edge) begin
      window_d = win_shift;
      to_cnt_d = '0;
      if (sync_hit) begin
        sync_d    = 1'b1;
        nib_cnt_d = '0;
      end else if (sync_q) begin
        frame_d[{nib_cnt_q, 2'b00} +: 4] = din_s2_q;
        nib_cnt_d = nib_cnt_q + 5'd1;
        wr_pend_d = (nib_cnt_q == 5'd31);
      end
    end else if (sync_q) begin
      if (to_cnt_q == TW'(SYNC_TIMEOUT - 1)) begin
        sync_d    = 1'b0;
        nib_cnt_d = '0;
        to_cnt_d  = '0;
      end else begin
        to_cnt_d = to_cnt_q + 1'b1;
      end
    end
  end

  assign full  = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign empty = (cnt_q == '0);
  assign wr_en = wr_pend_q & ~full;
  assign ovf   = wr_pend_q & full;

  assign cs_fall  = cs_prev_q & ~cs_s2_q;
  assign cs_rise  = ~cs_prev_q & cs_s2_q;
  assign sck_rise = ~sck_prev_q & sck_s2_q & ~cs_s2_q;
  assign sck_fall = sck_prev_q & ~sck_s2_q & ~cs_s2_q;

  // Byte 0 goes out first, MSB first: byte-reverse into a left shifter.
  always_comb begin
    tx_word = '0;
    for (int b = 0; b < 16; b++) begin
      tx_word[127-8*b -: 8] = mem_q[rd_ptr_q][8*b +: 8];
    end
  end

  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    no_pop_d  = no_pop_q;
    pop       = 1'b0;
    if (cs_fall) begin
      shreg_d   = empty ? '0 : tx_word;
      no_pop_d  = empty;
      bit_cnt_d = '0;
    end else begin
      if (sck_rise && bit_cnt_q != 8'hFF) bit_cnt_d = bit_cnt_q + 8'd1;
      if (sck_fall) shreg_d = {shreg_q[126:0], 1'b0};
    end
    if (cs_rise && bit_cnt_q == 8'd128 && !no_pop_q) pop = 1'b1;
  end

  always_comb begin
    cnt_d    = cnt_q + {{PW{1'b0}}, wr_en} - {{PW{1'b0}}, pop};
    wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, wr_en};
    rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop};
  end

  assign trig = {ovf, pop, wr_en};

  always_comb begin
    for (int i = 0; i < 3; i++) begin
      led_cnt_d[i] = led_cnt_q[i];
      if (trig[i]) led_cnt_d[i] = LW'(LED_STRETCH);
      else if (led_cnt_q[i] != '0) led_cnt_d[i] = led_cnt_q[i] - 1'b1;
    end
  end

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      tclk_s1_q   <= 1'b0;
      tclk_s2_q   <= 1'b0;
      tclk_prev_q <= 1'b0;
      din_s1_q    <= '0;
      din_s2_q    <= '0;
      cs_s1_q     <= 1'b1;
      cs_s2_q     <= 1'b1;
      cs_prev_q   <= 1'b1;
      sck_s1_q    <= 1'b0;
      sck_s2_q    <= 1'b0;
      sck_prev_q  <= 1'b0;
      window_q    <= '0;
      sync_q      <= 1'b0;
      nib_cnt_q   <= '0;
      frame_q     <= '0;
      wr_pend_q   <= 1'b0;
      to_cnt_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      no_pop_q    <= 1'b1;
      for (int i = 0; i < 3; i++) led_cnt_q[i] <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      tclk_s1_q   <= traceClk;
      tclk_s2_q   <= tclk_s1_q;
      tclk_prev_q <= tclk_s2_q;
      din_s1_q    <= traceDin;
      din_s2_q    <= din_s1_q;
      cs_s1_q     <= spics;
      cs_s2_q     <= cs_s1_q;
      cs_prev_q   <= cs_s2_q;
      sck_s1_q    <= spiclk;
      sck_s2_q    <= sck_s1_q;
      sck_prev_q  <= sck_s2_q;
      window_q    <= window_d;
      sync_q      <= sync_d;
      nib_cnt_q   <= nib_cnt_d;
      frame_q     <= frame_d;
      wr_pend_q   <= wr_pend_d;
      to_cnt_q    <= to_cnt_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      no_pop_q    <= no_pop_d;
      for (int i = 0; i < 3; i++) led_cnt_q[i] <= led_cnt_d[i];
      if (wr_en) mem_q[wr_ptr_q] <= frame_q;
    end
  end

  assign spitx     = ~cs_s2_q & shreg_q[127];
  assign sync_led  = sync_q;
  assign rxInd_led = (led_cnt_q[0] != '0);
  assign txInd_led = (led_cnt_q[1] != '0);
  assign txOvf_led = (led_cnt_q[2] != '0);
  assign cts       = ~empty;
  assign D6        = sync_q;
  assign D5        = trace_edge;
  assign D4        = wr_pend_q;
  assign D3        = cs_s2_q;
endmodule

// File: tb/tb_trace_port_capture.sv
// Bench for trace_port_capture: directed trace/SPI traffic,
// expected frames queued at send time and checked as SPI reads land.
module tb_trace_port_capture;
  logic       clkIn = 0;
  logic       rstIn = 0;
  logic [3:0] traceDin = 0;
  logic       traceClk = 0;
  logic       spics = 1;
  logic       spiclk = 0;
  logic       spirx = 0;
  logic       spitx, sync_led, rxInd_led, txInd_led, txOvf_led, cts;
  logic       D6, D5, D4, D3;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int base_wr;
  logic [127:0] exp_q [$];
  logic [127:0] got_q [$];

  trace_port_capture #(
    .FIFO_DEPTH(4), .LED_STRETCH(3000), .SYNC_TIMEOUT(400)
  ) dut (
    .clkIn(clkIn), .rstIn(rstIn), .traceDin(traceDin),
    .traceClk(traceClk), .spics(spics), .spiclk(spiclk),
    .spirx(spirx), .spitx(spitx), .sync_led(sync_led),
    .rxInd_led(rxInd_led), .txInd_led(txInd_led),
    .txOvf_led(txOvf_led), .cts(cts), .D6(D6), .D5(D5),
    .D4(D4), .D3(D3)
  );

  always #5 clkIn = ~clkIn;

  always @(posedge clkIn) if (D4) wr_cnt++;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clkIn);
  endtask

  task automatic send_nib(input logic [3:0] n);
    traceDin = n;
    cyc(4);
    traceClk = ~traceClk;
    cyc(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_nib(b[3:0]);
    send_nib(b[7:4]);
  endtask

  task automatic send_sync();
    repeat (7) send_byte(8'hFF);
    send_byte(8'h7F);
  endtask

  task automatic send_frame(input logic [127:0] f, input bit stored);
    for (int i = 0; i < 16; i++) send_byte(f[8*i +: 8]);
    if (stored) exp_q.push_back(f);
  endtask

  function automatic logic [127:0] seq_frame(input logic [7:0] base);
    logic [127:0] f;
    for (int i = 0; i < 16; i++) f[8*i +: 8] = base + 8'(i);
    return f;
  endfunction

  task automatic spi_read(input int nclk, input bit keep);
    logic [127:0] d;
    d = '0;
    spics = 0;
    cyc(16);
    for (int i = 0; i < nclk; i++) begin
      d[8*(i/8) + 7 - (i%8)] = spitx;
      spiclk = 1;
      cyc(8);
      spiclk = 0;
      cyc(8);
    end
    spics = 1;
    cyc(16);
    if (keep) got_q.push_back(d);
  endtask

  // Monitor: compares each completed SPI read against the scoreboard.
  initial begin
    logic [127:0] g;
    forever begin
      @(negedge clkIn);
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spi_frame: got %h expected none", g);
        end else begin
          chk("spi_frame", g, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] f2;
    f2 = 128'hEFCDAB8967452301_EFCDAB8967452301;
    cyc(5);
    chk("reset_outs",
        {118'd0, sync_led, rxInd_led, txInd_led, txOvf_led, cts,
         D6, D5, D4, D3, spitx},
        {118'd0, 10'b0000000010});
    rstIn = 1;
    cyc(5);

    // Unsynced traffic produces nothing.
    base_wr = wr_cnt;
    foreach (f2[i]) ; // no-op keeps f2 live
    send_byte(8'hAA); send_byte(8'h55); send_byte(8'hAA);
    send_byte(8'h55); send_byte(8'h66); send_byte(8'h99);
    send_byte(8'h66); send_byte(8'h99);
    cyc(8);
    chk("nosync_sync", sync_led, 0);
    chk("nosync_cts", cts, 0);
    chk("nosync_wr", wr_cnt - base_wr, 0);

    // Sync + one frame, then timeout boundary, then read.
    send_sync();
    send_frame(f2, 1);
    cyc(8);
    chk("s2_sync", sync_led, 1);
    chk("s2_cts", cts, 1);
    chk("s2_rxind", rxInd_led, 1);
    cyc(282);
    chk("to_before", sync_led, 1);
    cyc(150);
    chk("to_after", sync_led, 0);
    spi_read(128, 1);
    chk("s2_cts_after", cts, 0);
    chk("s2_txind", txInd_led, 1);

    // Resync mid-frame discards partial bytes.
    base_wr = wr_cnt;
    send_sync();
    send_byte(8'h01); send_byte(8'h23);
    send_sync();
    send_frame(seq_frame(8'h10), 1);
    cyc(8);
    chk("resync_wr", wr_cnt - base_wr, 1);
    chk("resync_cts", cts, 1);
    spi_read(128, 1);

    // Overflow: fifth frame dropped, first four retained in order.
    send_sync();
    for (int k = 0; k < 5; k++)
      send_frame(seq_frame(8'(8'h40 + 16*k)), k < 4);
    cyc(8);
    chk("ovf_cts", cts, 1);
    chk("ovf_led", txOvf_led, 1);
    for (int k = 0; k < 4; k++) spi_read(128, 1);
    chk("ovf_drain_cts", cts, 0);

    // Aborted read keeps the frame; empty read returns zeros.
    send_sync();
    send_frame(seq_frame(8'hC0), 1);
    cyc(8);
    spi_read(64, 0);
    chk("abort_cts", cts, 1);
    spi_read(128, 1);
    chk("full_read_cts", cts, 0);
    exp_q.push_back('0);
    spi_read(128, 1);
    chk("empty_read_cts", cts, 0);

    // Reset mid-frame, then recover.
    send_sync();
    send_frame(seq_frame(8'hD0), 0);
    send_sync();
    for (int i = 0; i < 5; i++) send_byte(8'(i));
    rstIn = 0;
    cyc(3);
    chk("midrst_outs",
        {118'd0, sync_led, rxInd_led, txInd_led, txOvf_led, cts,
         D6, D5, D4, D3, spitx},
        {118'd0, 10'b0000000010});
    rstIn = 1;
    cyc(5);
    send_sync();
    send_frame(f2, 1);
    cyc(8);
    chk("post_rst_sync", sync_led, 1);
    chk("post_rst_cts", cts, 1);
    spi_read(128, 1);
    chk("post_rst_cts_after", cts, 0);

    begin
      int n;
      n = 0;
      while (got_q.size() > 0 && n < 100) begin
        cyc(1);
        n++;
      end
    end
    chk("monitor_drained", got_q.size(), 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
